// File: rtl/xtea_pkg.sv
// Shared XTEA constants, FSM state type and round helpers for the encryptor and decryptor.
package xtea_pkg;

    localparam logic [31:0] DELTA              = 32'h9E3779B9;
    localparam logic [31:0] DEC_SUM_INIT       = 32'hC6EF3720;
    localparam int          NUM_CYCLES_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } xtea_state_e;

    // k[0] lives in the most significant word of the 128-bit key.
    function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = key[127:96];
            2'd1:    w = key[95:64];
            2'd2:    w = key[63:32];
            default: w = key[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

endpackage

// File: rtl/xtea_dec_round.sv
// One full XTEA decryption cycle (two Feistel rounds), purely combinational.
module xtea_dec_round
    import xtea_pkg::*;
(
    input  logic [31:0]  v0_i,
    input  logic [31:0]  v1_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    output logic [31:0]  v0_o,
    output logic [31:0]  v1_o,
    output logic [31:0]  sum_o
);

    // The v0 half uses the already-updated v1 and the decremented sum.
    assign v1_o  = v1_i - (mix(v0_i) ^ (sum_i + key_word(key_i, sum_i[12:11])));
    assign sum_o = sum_i - DELTA;
    assign v0_o  = v0_i - (mix(v1_o) ^ (sum_o + key_word(key_i, sum_o[1:0])));

endmodule

// File: rtl/xtea_dec.sv
// Iterative XTEA decryptor: two 64-bit blocks in parallel, one XTEA cycle per clock.
module xtea_dec
    import xtea_pkg::*;
#(
    parameter int NUM_CYCLES = NUM_CYCLES_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         busy,
    output logic         ready,
    output logic [127:0] data_out
);

    localparam int              CW       = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST     = CW'(NUM_CYCLES - 1);
    localparam logic [31:0]     SUM_INIT = (NUM_CYCLES == NUM_CYCLES_DEFAULT) ?
                                           DEC_SUM_INIT : DELTA * 32'(NUM_CYCLES);

    xtea_state_e    state_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    sum_q;
    logic [127:0]   key_q;
    logic [31:0]    v0_q [2];
    logic [31:0]    v1_q [2];
    logic [127:0]   data_out_q;
    logic           busy_q;
    logic           ready_q;

    logic [31:0]    v0_d  [2];
    logic [31:0]    v1_d  [2];
    logic [31:0]    sum_d [2];

    // Block A is index 0 (data_in[127:64]); only its sum output drives sum_q.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_blk
            xtea_dec_round u_round (
                .v0_i  (v0_q[gi]),
                .v1_i  (v1_q[gi]),
                .sum_i (sum_q),
                .key_i (key_q),
                .v0_o  (v0_d[gi]),
                .v1_o  (v1_d[gi]),
                .sum_o (sum_d[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            key_q      <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                v0_q[i] <= '0;
                v1_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 2; i++) begin
                            v0_q[i] <= data_in[127 - 64*i -: 32];
                            v1_q[i] <= data_in[95  - 64*i -: 32];
                        end
                        key_q   <= key;
                        sum_q   <= SUM_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < 2; i++) begin
                        v0_q[i] <= v0_d[i];
                        v1_q[i] <= v1_d[i];
                    end
                    sum_q <= sum_d[0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        data_out_q <= {v0_d[0], v1_d[0], v0_d[1], v1_d[1]};
                        ready_q    <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign data_out = data_out_q;

endmodule
